generic_sram_line_en_mem: RTL and testbench

Behavioural/synthesizable SRAM target at the `sram` end of `generic_sram_line_en_if`, sitting directly downstream of the Wishbone line-enable SRAM bridge. It stores `2**ADDR_WIDTH` words of `DATA_WIDTH` bits and serves reads with a configurable registered latency. After reset it can optionally sweep the whole array to a fill value before accepting traffic. It also exports status strobes so benches and system logic can observe readiness and read completion.

---
 rtl/generic_sram_line_en_mem_if.sv | 14 +
 rtl/generic_sram_line_en_mem.sv | 97 +++++++++
 tb/tb_generic_sram_line_en_mem.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/generic_sram_line_en_mem_if.sv
// SRAM-side port bundle between the Wishbone line-enable bridge and the memory.
interface generic_sram_line_en_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  read_en;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  modport sram   (input addr, read_en, write_en, write_data, output read_data);
  modport master (output addr, read_en, write_en, write_data, input read_data);
endinterface

// File: rtl/generic_sram_line_en_mem.sv
// Word-addressed SRAM with an optional post-reset fill sweep and a
// configurable-depth registered read pipeline.
module generic_sram_line_en_mem #(
  parameter int                   ADDR_WIDTH    = 8,
  parameter int                   DATA_WIDTH    = 32,
  parameter int                   READ_LATENCY  = 1,
  parameter int                   INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  generic_sram_line_en_if.sram    sram_s,
  output logic                    init_done,
  output logic                    rd_valid
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]                    cnt_q, cnt_d;
  logic                                     init_done_q, init_done_d;
  logic [READ_LATENCY-1:0]                  vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]  dat_pipe_q, dat_pipe_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rd_accept;

  assign mem_rdata = mem[sram_s.addr];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = sram_s.addr;
    mem_wdata = sram_s.write_data;
    rd_accept = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Sweep owns the array; bus traffic is dropped until READY.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VALUE;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_READY;
      end
      default: begin
        mem_we    = sram_s.write_en;
        rd_accept = sram_s.read_en & ~sram_s.write_en;
      end
    endcase
    init_done_d = (state_d == ST_READY);

    // Data stages only load on a valid beat so the output holds the last read.
    vld_pipe_d    = vld_pipe_q;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[0] = rd_accept;
    if (rd_accept) dat_pipe_d[0] = mem_rdata;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      if (vld_pipe_q[i-1]) dat_pipe_d[i] = dat_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      vld_pipe_q  <= '0;
      dat_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      vld_pipe_q  <= vld_pipe_d;
      dat_pipe_q  <= dat_pipe_d;
    end
  end

  // Array kept out of reset so it maps onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (rstn && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign sram_s.read_data = dat_pipe_q[READ_LATENCY-1];
  assign rd_valid         = vld_pipe_q[READ_LATENCY-1];
  assign init_done        = init_done_q;
endmodule

// File: tb/tb_generic_sram_line_en_mem.sv
// Directed bench: four memories (latency 1..4) share one stimulus bus.
module tb_generic_sram_line_en_mem;
  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  addr;
  logic        re, we;
  logic [31:0] wd;
  logic [3:0]        rdv, idn;
  logic [3:0][31:0]  rdd;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // g=0: lat1 swept to DEADBEEF; g=1,2: lat2/3 no sweep; g=3: lat4 swept to 0.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int          LAT  = g + 1;
    localparam int          INIT = (g == 0 || g == 3) ? 1 : 0;
    localparam logic [31:0] IV   = (g == 0) ? 32'hDEADBEEF : 32'h0;
    logic rv, id;
    generic_sram_line_en_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
    assign bus.addr       = addr;
    assign bus.read_en    = re;
    assign bus.write_en   = we;
    assign bus.write_data = wd;
    generic_sram_line_en_mem #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(LAT),
      .INIT_ON_RESET(INIT), .INIT_VALUE(IV)
    ) u_mem (
      .clk(clk), .rstn(rstn), .sram_s(bus), .init_done(id), .rd_valid(rv)
    );
    assign rdv[g] = rv;
    assign idn[g] = id;
    assign rdd[g] = bus.read_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first_k;
    rstn = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wd = '0;
    step(); step();
    checks++;
    if (rdv !== 4'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0000", rdv); end
    checks++;
    if (idn !== 4'b0) begin errors++; $display("FAIL reset_init_done got %b want 0000", idn); end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (rdd[g] !== 32'h0) begin errors++; $display("FAIL reset_read_data[%0d] got %h want 0", g, rdd[g]); end
    end
    // Release with a write to address 3 that the sweeping memories must drop.
    rstn = 1'b1; we = 1'b1; addr = 4'd3; wd = 32'h1234;
    first_k = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        we = 1'b0;
        checks++;
        if (idn[1] !== 1'b1) begin errors++; $display("FAIL noinit_done_1cyc got %b want 1", idn[1]); end
      end
      if (first_k < 0 && idn[0] === 1'b1) first_k = k;
    end
    checks++;
    if (first_k != 16) begin errors++; $display("FAIL init_done_rise got %0d want 16", first_k); end
    checks++;
    if (idn !== 4'b1111) begin errors++; $display("FAIL all_ready got %b want 1111", idn); end
  endtask

  task automatic test_init_values();
    logic [3:0] addrs [3];
    addrs[0] = 4'd0; addrs[1] = 4'd15; addrs[2] = 4'd3;
    for (int i = 0; i < 3; i++) begin
      re = 1'b1; addr = addrs[i];
      step();
      re = 1'b0;
      checks++;
      if (rdv[0] !== 1'b1 || rdd[0] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL init_read a=%0d got v=%b d=%h want v=1 d=deadbeef", addrs[i], rdv[0], rdd[0]);
      end
    end
    step();
    checks++;
    if (rdv[0] !== 1'b0 || rdd[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL init_hold got v=%b d=%h want v=0 d=deadbeef", rdv[0], rdd[0]);
    end
    repeat (4) step();
  endtask

  task automatic test_write_read_latency();
    we = 1'b1; addr = 4'd5; wd = 32'h12345678;
    step();
    we = 1'b0; re = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      re = 1'b0;
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rdv[g] !== (k == g)) begin
          errors++; $display("FAIL lat%0d_valid k=%0d got %b want %b", g + 1, k, rdv[g], (k == g));
        end else if (k == g && rdd[g] !== 32'h12345678) begin
          errors++; $display("FAIL lat%0d_data got %h want 12345678", g + 1, rdd[g]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ev;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; addr = 4'(i); wd = 32'(10 + i);
      step();
    end
    we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      re = (k < 4); addr = 4'(k);
      step();
      for (int g = 0; g < 4; g++) begin
        ev = (k >= g) && (k <= g + 3);
        checks++;
        if (rdv[g] !== ev) begin
          errors++; $display("FAIL b2b_valid lat%0d k=%0d got %b want %b", g + 1, k, rdv[g], ev);
        end else if (ev && rdd[g] !== 32'(10 + k - g)) begin
          errors++; $display("FAIL b2b_data lat%0d k=%0d got %0d want %0d", g + 1, k, rdd[g], 10 + k - g);
        end else if (k > g + 3 && rdd[g] !== 32'd13) begin
          errors++; $display("FAIL b2b_hold lat%0d k=%0d got %0d want 13", g + 1, k, rdd[g]);
        end
      end
    end
    re = 1'b0;
  endtask

  task automatic test_simul_rw();
    re = 1'b1; we = 1'b1; addr = 4'd7; wd = 32'hA5;
    for (int k = 0; k < 5; k++) begin
      step();
      re = 1'b0; we = 1'b0;
      checks++;
      if (rdv !== 4'b0) begin errors++; $display("FAIL rw_no_valid k=%0d got %b want 0000", k, rdv); end
    end
    re = 1'b1; addr = 4'd7;
    for (int k = 0; k < 4; k++) begin
      step();
      re = 1'b0;
      for (int g = 0; g < 4; g++) begin
        if (k == g) begin
          checks++;
          if (rdv[g] !== 1'b1 || rdd[g] !== 32'hA5) begin
            errors++; $display("FAIL rw_readback lat%0d got v=%b d=%h want v=1 d=a5", g + 1, rdv[g], rdd[g]);
          end
        end
      end
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid_read();
    int first_k;
    int bad_valid;
    re = 1'b1; addr = 4'd0;
    step();
    addr = 4'd1;
    step();
    re = 1'b0; rstn = 1'b0;
    bad_valid = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (rdv[3] !== 1'b0 || rdd[3] !== 32'h0 || idn[3] !== 1'b0) begin
        errors++; $display("FAIL midrst_in_reset k=%0d got v=%b d=%h id=%b want 0/0/0", k, rdv[3], rdd[3], idn[3]);
      end
    end
    rstn = 1'b1;
    first_k = -1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (rdv[3] !== 1'b0) bad_valid++;
      if (first_k < 0 && idn[3] === 1'b1) first_k = k;
    end
    checks++;
    if (bad_valid != 0) begin errors++; $display("FAIL midrst_flush got %0d valids want 0", bad_valid); end
    checks++;
    if (first_k != 16) begin errors++; $display("FAIL midrst_resweep got %0d want 16", first_k); end
  endtask

  task automatic test_bridge();
    // Wishbone write: STB&WE maps to write_en, ACK follows one cycle later.
    we = 1'b1; addr = 4'd9; wd = 32'hCAFE0001;
    step();
    we = 1'b0;
    step();
    re = 1'b1; addr = 4'd9;
    step();
    re = 1'b0;
    checks++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 32'hCAFE0001) begin
      errors++; $display("FAIL wb_ack_dat_r got v=%b d=%h want v=1 d=cafe0001", rdv[0], rdd[0]);
    end
    // Address 1 held 11 before the mid-read reset; the new sweep overwrote it.
    re = 1'b1; addr = 4'd1;
    step();
    re = 1'b0;
    checks++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wb_resweep_read got v=%b d=%h want v=1 d=deadbeef", rdv[0], rdd[0]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_write_read_latency();
    test_back_to_back();
    test_simul_rw();
    test_reset_mid_read();
    test_bridge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
